// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath: fetch, decode, execute
// and the external memory read/write handshake. Outputs are decoded from state and isr.
module ctrl_fsm #(
   parameter int unsigned WAIT_LIMIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] isr,
   input  logic        mem_rdy,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [2:0]  funsel,
   output logic [2:0]  rsel,
   output logic        lsp,
   output logic        lpc,
   output logic        lmdr,
   output logic        lmar,
   output logic        lisr,
   output logic        ly,
   output logic        wrr,
   output logic        spmar,
   output logic        pcmar,
   output logic        mdrz,
   output logic        mdrm,
   output logic        tr,
   output logic        tsp,
   output logic        tpc,
   output logic        tmdr,
   output logic        tisr,
   output logic        sflag,
   output logic        cc,
   output logic        halted
);

   localparam logic [2:0] FN_ADD   = 3'b000;
   localparam logic [2:0] FN_INC   = 3'b001;
   localparam logic [2:0] FN_DEC   = 3'b010;
   localparam logic [2:0] FN_PASSX = 3'b011;

   typedef enum logic [4:0] {
      S_F0, S_F1, S_F2, S_F3, S_DEC,
      S_B0, S_B1,
      S_A0, S_A1,
      S_P0, S_P1, S_P2,
      S_Q0, S_Q1, S_Q2, S_Q3,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] wcnt;

   logic [3:0] opc;
   logic [2:0] rd_f;
   logic [2:0] rs_f;
   logic [2:0] op_f;
   logic       unused_isr;
   logic       req;
   logic       limit_hit;

   assign opc        = isr[15:12];
   assign rd_f       = isr[11:9];
   assign rs_f       = isr[8:6];
   assign op_f       = isr[2:0];
   assign unused_isr = ^isr[5:3];

   assign req       = (state == S_F1) || (state == S_Q1) || (state == S_P2);
   // Only meaningful on a cycle where the request is still waiting for mem_rdy.
   assign limit_hit = (WAIT_LIMIT != 0) && (wcnt == WAIT_LIMIT - 32'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_F0;
         wcnt  <= '0;
      end else begin
         if (req) begin
            if (mem_rdy || limit_hit)
               wcnt <= '0;
            else if (WAIT_LIMIT != 0)
               wcnt <= wcnt + 32'd1;
         end

         case (state)
            S_F0:  state <= S_F1;
            S_F1: begin
               if (mem_rdy)
                  state <= S_F2;
               else if (limit_hit)
                  state <= S_HALT;
            end
            S_F2:  state <= S_F3;
            S_F3:  state <= S_DEC;
            S_DEC: begin
               case (opc)
                  4'h9:                state <= S_A0;
                  4'hA:                state <= S_P0;
                  4'hB:                state <= S_Q0;
                  4'hC, 4'hD, 4'hE:    state <= S_F0;
                  4'hF:                state <= S_HALT;
                  default:             state <= S_B0;
               endcase
            end
            S_B0:  state <= S_B1;
            S_B1:  state <= S_F0;
            S_A0:  state <= S_A1;
            S_A1:  state <= S_F0;
            S_P0:  state <= S_P1;
            S_P1:  state <= S_P2;
            S_P2: begin
               if (mem_rdy)
                  state <= S_F0;
               else if (limit_hit)
                  state <= S_HALT;
            end
            S_Q0:  state <= S_Q1;
            S_Q1: begin
               if (mem_rdy)
                  state <= S_Q2;
               else if (limit_hit)
                  state <= S_HALT;
            end
            S_Q2:  state <= S_Q3;
            S_Q3:  state <= S_F0;
            S_HALT: state <= S_HALT;
            default: state <= S_F0;
         endcase
      end
   end

   // Reset gates every strobe so a request in flight is dropped immediately.
   always_comb begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      funsel = FN_ADD;
      rsel   = '0;
      lsp    = 1'b0;
      lpc    = 1'b0;
      lmdr   = 1'b0;
      lmar   = 1'b0;
      lisr   = 1'b0;
      ly     = 1'b0;
      wrr    = 1'b0;
      spmar  = 1'b0;
      pcmar  = 1'b0;
      mdrz   = 1'b0;
      mdrm   = 1'b0;
      tr     = 1'b0;
      tsp    = 1'b0;
      tpc    = 1'b0;
      tmdr   = 1'b0;
      tisr   = 1'b0;
      sflag  = 1'b0;
      cc     = 1'b0;
      halted = 1'b0;
      if (!reset) begin
         case (state)
            S_F0: begin
               pcmar = 1'b1;
               lmar  = 1'b1;
            end
            S_F1: begin
               mem_rd = 1'b1;
               mdrm   = 1'b1;
               lmdr   = 1'b1;
            end
            S_F2: lisr = 1'b1;
            S_F3: begin
               tpc    = 1'b1;
               funsel = FN_INC;
               lpc    = 1'b1;
            end
            S_B0: begin
               tisr = 1'b1;
               ly   = 1'b1;
            end
            S_B1: begin
               tpc    = 1'b1;
               funsel = FN_ADD;
               lpc    = 1'b1;
               cc     = 1'b1;
            end
            S_A0: begin
               tr   = 1'b1;
               rsel = rs_f;
               ly   = 1'b1;
            end
            S_A1: begin
               tr     = 1'b1;
               rsel   = rd_f;
               funsel = op_f;
               wrr    = 1'b1;
               sflag  = 1'b1;
            end
            S_P0: begin
               tsp    = 1'b1;
               funsel = FN_DEC;
               lsp    = 1'b1;
            end
            S_P1: begin
               spmar  = 1'b1;
               lmar   = 1'b1;
               tr     = 1'b1;
               rsel   = rd_f;
               funsel = FN_PASSX;
               mdrz   = 1'b1;
               lmdr   = 1'b1;
            end
            S_P2: mem_wr = 1'b1;
            S_Q0: begin
               spmar = 1'b1;
               lmar  = 1'b1;
            end
            S_Q1: begin
               mem_rd = 1'b1;
               mdrm   = 1'b1;
               lmdr   = 1'b1;
            end
            S_Q2: begin
               tmdr   = 1'b1;
               funsel = FN_PASSX;
               rsel   = rd_f;
               wrr    = 1'b1;
            end
            S_Q3: begin
               tsp    = 1'b1;
               funsel = FN_INC;
               lsp    = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: a datapath + memory model driven by the DUT strobes, compared
// against an instruction-level model of the machine, with random programs and latencies.
module tb_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] isr;
   logic        mem_rdy;
   logic        mem_rd, mem_wr;
   logic [2:0]  funsel, rsel;
   logic        lsp, lpc, lmdr, lmar, lisr, ly, wrr, spmar, pcmar, mdrz, mdrm;
   logic        tr, tsp, tpc, tmdr, tisr, sflag, cc, halted;

   always #5 clk = ~clk;

   ctrl_fsm #(.WAIT_LIMIT(8)) dut (
      .clk(clk), .reset(reset), .isr(isr), .mem_rdy(mem_rdy),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .funsel(funsel), .rsel(rsel),
      .lsp(lsp), .lpc(lpc), .lmdr(lmdr), .lmar(lmar), .lisr(lisr), .ly(ly),
      .wrr(wrr), .spmar(spmar), .pcmar(pcmar), .mdrz(mdrz), .mdrm(mdrm),
      .tr(tr), .tsp(tsp), .tpc(tpc), .tmdr(tmdr), .tisr(tisr),
      .sflag(sflag), .cc(cc), .halted(halted)
   );

   typedef struct packed {
      logic       mem_rd, mem_wr;
      logic [2:0] funsel, rsel;
      logic       lsp, lpc, lmdr, lmar, lisr, ly, wrr, spmar, pcmar, mdrz, mdrm;
      logic       tr, tsp, tpc, tmdr, tisr, sflag, cc, halted;
   } outs_t;

   outs_t o;
   outs_t trace[$];
   int    n_chk = 0;
   int    n_err = 0;

   logic [15:0] dmem [0:65535];
   logic [15:0] amem [0:65535];
   logic [15:0] dp_pc, dp_sp, dp_y, dp_mdr, dp_mar;
   logic [15:0] dp_r [8];
   logic        dp_zf;
   logic [15:0] a_pc, a_sp;
   logic [15:0] a_r [8];
   logic        a_zf;

   bit req_act;
   int wleft, req_idx, lat_f, lat_e, n_rd, n_wr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic outs_t grab();
      outs_t g;
      g = '{mem_rd, mem_wr, funsel, rsel, lsp, lpc, lmdr, lmar, lisr, ly, wrr, spmar,
            pcmar, mdrz, mdrm, tr, tsp, tpc, tmdr, tisr, sflag, cc, halted};
      return g;
   endfunction

   function automatic logic [15:0] alu(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
      case (f)
         3'd0: return x + y;
         3'd1: return x + 16'd1;
         3'd2: return x - 16'd1;
         3'd3: return x;
         3'd4: return x & y;
         3'd5: return x | y;
         3'd6: return x ^ y;
         default: return ~x;
      endcase
   endfunction

   // Bench datapath condition: 0 always, odd codes on Z set, even codes on Z clear.
   function automatic logic cond_true(input logic [3:0] c, input logic zf);
      if (c == 4'd0) return 1'b1;
      return c[0] ? zf : !zf;
   endfunction

   function automatic outs_t f0v();
      outs_t e;
      e = '0; e.pcmar = 1'b1; e.lmar = 1'b1;
      return e;
   endfunction

   // Process the cycle sampled in o: respond on the memory bus, update the datapath, advance.
   task automatic tick();
      outs_t       c;
      logic [15:0] x, z, memout, pc0, sp0, mdr0;
      logic        rdy, req, take;
      c = o;
      trace.push_back(c);
      check("xbus_excl", 32'($countones({c.tr, c.tsp, c.tpc, c.tmdr, c.tisr}) <= 1), 32'd1);
      check("rd_wr_excl", 32'(c.mem_rd & c.mem_wr), 32'd0);
      req = c.mem_rd | c.mem_wr;
      if (req) begin
         if (!req_act) begin
            req_act = 1'b1;
            wleft   = (req_idx == 0) ? lat_f : lat_e;
            req_idx++;
         end
         rdy = (wleft == 0);
         if (rdy) req_act = 1'b0;
         else     wleft--;
      end else begin
         rdy = 1'($urandom_range(0, 1));
      end
      mem_rdy = rdy;
      if (c.mem_rd) n_rd++;
      if (c.mem_wr) n_wr++;

      pc0 = dp_pc; sp0 = dp_sp; mdr0 = dp_mdr;
      x = c.tr ? dp_r[c.rsel] : c.tsp ? dp_sp : c.tpc ? dp_pc : c.tmdr ? dp_mdr :
          c.tisr ? {{4{isr[11]}}, isr[11:0]} : 16'h0000;
      z = alu(c.funsel, x, dp_y);
      memout = dmem[dp_mar];
      take = cond_true(isr[15:12], dp_zf);
      if (c.mem_wr && rdy) dmem[dp_mar] = mdr0;
      if (c.lpc && (!c.cc || take)) dp_pc = z;
      if (c.sflag) dp_zf = (z == 16'h0000);
      if (c.ly)    dp_y = x;
      if (c.lsp)   dp_sp = z;
      if (c.wrr)   dp_r[c.rsel] = z;
      if (c.lmar)  dp_mar = c.spmar ? sp0 : (c.pcmar ? pc0 : dp_mar);
      if (c.lmdr)  dp_mdr = c.mdrz ? z : (c.mdrm ? memout : dp_mdr);
      if (c.lisr)  isr = mdr0;
      @(negedge clk);
      o = grab();
   endtask

   // Instruction-level model: one whole instruction, returns its base cycle count.
   task automatic isa_step(input logic [15:0] ins, output int base);
      logic [3:0]  c;
      logic [2:0]  rd, rs;
      logic [15:0] res;
      c  = ins[15:12];
      rd = ins[11:9];
      rs = ins[8:6];
      a_pc = a_pc + 16'd1;
      base = 5;
      if (c <= 4'd8) begin
         if (cond_true(c, a_zf)) a_pc = a_pc + {{4{ins[11]}}, ins[11:0]};
         base = 7;
      end else if (c == 4'h9) begin
         res = alu(ins[2:0], a_r[rd], a_r[rs]);
         a_r[rd] = res;
         a_zf = (res == 16'h0000);
         base = 7;
      end else if (c == 4'hA) begin
         a_sp = a_sp - 16'd1;
         amem[a_sp] = a_r[rd];
         base = 8;
      end else if (c == 4'hB) begin
         a_r[rd] = amem[a_sp];
         a_sp = a_sp + 16'd1;
         base = 9;
      end
   endtask

   task automatic exec(input bit dir, input logic [15:0] ins, input int lf, input int le);
      logic [15:0] ai;
      logic [3:0]  c;
      int          base, cyc, memop;
      if (dir) begin
         dmem[dp_pc] = ins;
         amem[a_pc]  = ins;
      end
      ai = amem[a_pc];
      c  = ai[15:12];
      isa_step(ai, base);
      lat_f = lf; lat_e = le; req_idx = 0; n_rd = 0; n_wr = 0; cyc = 0;
      trace.delete();
      do begin
         tick();
         cyc++;
      end while (!(o.pcmar && o.lmar) && !o.halted && cyc < 400);
      memop = (c == 4'hA || c == 4'hB) ? 1 : 0;
      check("cycles", 32'(cyc), 32'(base + lf + memop * le));
      check("rd_cycles", 32'(n_rd), 32'(lf + 1 + ((c == 4'hB) ? le + 1 : 0)));
      check("wr_cycles", 32'(n_wr), 32'((c == 4'hA) ? le + 1 : 0));
      check("halted", 32'(o.halted), 32'(c == 4'hF));
      check("isr_fetch", 32'(isr), 32'(ai));
      check("pc", 32'(dp_pc), 32'(a_pc));
      check("sp", 32'(dp_sp), 32'(a_sp));
      check("zflag", 32'(dp_zf), 32'(a_zf));
      for (int i = 0; i < 8; i++) check("reg", 32'(dp_r[i]), 32'(a_r[i]));
      if (c == 4'hA) check("push_mem", 32'(dmem[a_sp]), 32'(amem[a_sp]));
   endtask

   // Called at a negedge; leaves o holding the first post-reset (F0) cycle.
   task automatic do_reset(input int n);
      reset = 1'b1;
      mem_rdy = 1'b0;
      #1;
      o = grab();
      check("rst_zero", 32'(o), 32'd0);
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         o = grab();
         check("rst_zero", 32'(o), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      req_act = 1'b0;
      #1;
      o = grab();
      check("rst_f0", 32'(o), 32'(f0v()));
   endtask

   initial begin
      outs_t       e;
      logic [15:0] w, fa;
      int          cyc;
      reset = 1'b1;
      mem_rdy = 1'b0;
      isr = 16'h0000;
      for (int i = 0; i < 65536; i++) begin
         w = {4'($urandom_range(0, 14)), 12'($urandom)};
         dmem[i] = w;
         amem[i] = w;
      end
      for (int i = 0; i < 8; i++) begin
         dp_r[i] = 16'($urandom);
         a_r[i]  = dp_r[i];
      end
      dp_pc = 16'h0100; dp_sp = 16'($urandom); dp_y = '0; dp_mdr = '0; dp_mar = '0; dp_zf = 1'b0;
      a_pc = dp_pc; a_sp = dp_sp; a_zf = dp_zf;
      req_act = 1'b0;

      @(negedge clk);
      do_reset(3);

      // Reset arriving mid-fetch with mem_rd high.
      lat_f = 100; req_idx = 0;
      tick();
      check("f1_rd", 32'(o.mem_rd), 32'd1);
      tick();
      do_reset(4);

      // ALU Rd=5 Rs=1 op=PASSX, zero-wait memory.
      exec(1'b1, 16'h9A43, 0, 0);
      e = '0; e.tr = 1'b1; e.rsel = 3'd1; e.ly = 1'b1;
      check("alu_a0", 32'(trace[5]), 32'(e));
      e = '0; e.tr = 1'b1; e.rsel = 3'd5; e.wrr = 1'b1; e.sflag = 1'b1; e.funsel = 3'b011;
      check("alu_a1", 32'(trace[6]), 32'(e));

      // Unconditional branch by -2.
      fa = dp_pc;
      exec(1'b1, 16'h0FFE, 0, 0);
      e = '0; e.tisr = 1'b1; e.ly = 1'b1;
      check("br_b0", 32'(trace[5]), 32'(e));
      e = '0; e.tpc = 1'b1; e.lpc = 1'b1; e.cc = 1'b1;
      check("br_b1", 32'(trace[6]), 32'(e));
      check("br_target", 32'(dp_pc), 32'(fa - 16'd1));

      // PUSH R3 with the write held off four cycles.
      exec(1'b1, 16'hA600, 0, 4);
      check("push_wr5", 32'(n_wr), 32'd5);
      e = '0; e.mem_wr = 1'b1;
      foreach (trace[i]) if (trace[i].mem_wr) check("push_p2", 32'(trace[i]), 32'(e));

      // POP R1 from the top of memory; SP wraps to 0000.
      dp_sp = 16'hFFFF; a_sp = 16'hFFFF;
      exec(1'b1, 16'hB200, 0, 2);
      e = '0; e.tmdr = 1'b1; e.funsel = 3'b011; e.rsel = 3'd1; e.wrr = 1'b1;
      check("pop_q2", 32'(trace[7 + 2]), 32'(e));
      e = '0; e.tsp = 1'b1; e.funsel = 3'b001; e.lsp = 1'b1;
      check("pop_q3", 32'(trace[8 + 2]), 32'(e));
      check("pop_sp_wrap", 32'(dp_sp), 32'h0000);

      for (int n = 0; n < 300; n++)
         exec(1'b0, 16'h0000, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));

      // HALT is sticky until reset.
      exec(1'b1, 16'hF000, 1, 0);
      e = '0; e.halted = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halt_hold", 32'(o), 32'(e));
      end
      @(negedge clk);
      do_reset(2);

      // Fetch never acknowledged: WAIT_LIMIT=8 request cycles, then HALT.
      lat_f = 1000; req_idx = 0; n_rd = 0; cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!o.halted && cyc < 100);
      check("wl_rd_cycles", 32'(n_rd), 32'd8);
      check("wl_cycles", 32'(cyc), 32'd9);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wl_hold", 32'(o), 32'(e));
      end
      @(negedge clk);
      do_reset(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
